apb_master: RTL and testbench

- Single-outstanding APB master bridge at the front of the peripheral subsystem.
- Accepts read/write commands on a valid/ready command port and drives the APB SETUP and ACCESS phases into the APB bus decoder's slave port.
- Waits for PREADY with a bounded timeout, then returns read data and an error flag on a valid/ready response port.
- The timeout guarantees a response when no slave asserts PREADY, e.g. for unmapped addresses.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_timeout_cnt.sv | 40 ++++
 rtl/apb_master.sv | 147 ++++++++++++++
 tb/tb_apb_master.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB subsystem definitions: transfer FSM encoding and default bus geometry.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } apb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH     = 32;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter: clear on command accept, count wait states,
// flag the last allowed ACCESS cycle.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The FSM stops enabling once this is high, so the counter never wraps.
  assign tc_o = (cnt_q == CntMax);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: valid/ready command in, SETUP/ACCESS on the bus,
// registered response out, with a bounded ACCESS phase for unmapped addresses.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLAVEERR
);

  apb_state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic pwrite_q, pwrite_d;
  logic psel_q, psel_d;
  logic penable_q, penable_d;
  logic rsp_valid_q, rsp_valid_d;
  logic rsp_err_q, rsp_err_d;
  logic cnt_clr, cnt_en, cnt_tc;
  logic access_done;

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i (PCLK),
    .rst_ni(PRESETn),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    access_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          psel_d   = 1'b1;
          cnt_clr  = 1'b1;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        state_d   = StAccess;
      end
      StAccess: begin
        // PREADY wins over the timeout on the last allowed cycle.
        if (PREADY) begin
          access_done = 1'b1;
          rsp_err_d   = PSLAVEERR;
          rdata_d     = (!pwrite_q && !PSLAVEERR) ? PRDATA : '0;
        end else if (cnt_tc) begin
          access_done = 1'b1;
          rsp_err_d   = 1'b1;
          rdata_d     = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (access_done) begin
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      rsp_valid_d = 1'b1;
      state_d     = StResp;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rdata_q     <= rdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus queues expected transfers, a negedge
// monitor checks bus phases, latency and the response against the queue head.
module tb_apb_master;

  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [DW-1:0] cmd_addr, cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [DW-1:0] PADDR, PWDATA, PRDATA;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLAVEERR;

  apb_master #(
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA),
    .PSLAVEERR(PSLAVEERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_rsp = 0;
  int exp_n = 0;
  int last_hs = 0;
  int acc_cyc = 0;
  bit in_xfer = 0;
  int en_cnt = 0;
  exp_t cur;

  // Slave model: PREADY rises on ACCESS cycle sl_ws+1 (0-based count sl_ws).
  int          sl_ws = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err = 1'b0;
  int          acc_cnt = 0;

  assign PRDATA    = sl_rdata;
  assign PSLAVEERR = sl_err;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge PCLK) begin
    if (!PRESETn || !(PSEL && PENABLE)) begin
      PREADY  = 1'b0;
      acc_cnt = 0;
    end else begin
      PREADY  = (acc_cnt == sl_ws);
      acc_cnt = acc_cnt + 1;
    end
  end

  always @(negedge PCLK) begin : mon
    int k;
    if (!PRESETn) begin
      in_xfer = 0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        if (in_xfer) begin
          chk("rsp_latency", cyc - acc_cyc, sb[0].lat);
          chk("penable_cycles", en_cnt, sb[0].lat - 2);
          in_xfer = 0;
        end
        chk("rsp_rdata", rsp_rdata, sb[0].rdata);
        chk("rsp_err", 32'(rsp_err), 32'(sb[0].err));
        chk("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        chk("psel_in_resp", 32'(PSEL), 32'd0);
        chk("penable_in_resp", 32'(PENABLE), 32'd0);
        if (rsp_ready) begin
          void'(sb.pop_front());
          n_rsp++;
          last_hs = cyc;
        end
      end
    end else if (in_xfer) begin
      k = cyc - acc_cyc;
      chk("psel", 32'(PSEL), 32'd1);
      chk("penable", 32'(PENABLE), 32'(k >= 2));
      chk("paddr", PADDR, cur.addr);
      chk("pwdata", PWDATA, cur.wdata);
      chk("pwrite", 32'(PWRITE), 32'(cur.wr));
      chk("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (PENABLE) en_cnt++;
      if (k >= cur.lat) begin
        chk("rsp_valid_at_lat", 32'(rsp_valid), 32'd1);
        in_xfer = 0;
      end
    end else if (cmd_valid && cmd_ready && sb.size() > 0) begin
      in_xfer = 1;
      acc_cyc = cyc;
      en_cnt  = 0;
      cur     = sb[0];
    end
  end

  task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input logic err, input int lat);
    exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = rdata; e.err = err; e.lat = lat;
    sb.push_back(e);
    exp_n++;
  endtask

  task automatic wait_accept();
    bit got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (cmd_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("cmd_accept", 32'(cmd_ready), 32'd1);
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge PCLK);
    #1;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_valid = 1'b1;
    wait_accept();
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 100; i++) begin
      if (n_rsp >= exp_n) break;
      @(negedge PCLK);
    end
    chk("rsp_count", n_rsp, exp_n);
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int ws, input logic [31:0] prd, input logic perr,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat);
    sl_ws = ws; sl_rdata = prd; sl_err = perr;
    push(wr, addr, wdata, exp_rd, exp_err, lat);
    issue(wr, addr, wdata);
    wait_rsp();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
    #1;
    chk("rst_psel", 32'(PSEL), 32'd0);
    chk("rst_penable", 32'(PENABLE), 32'd0);
    chk("rst_pwrite", 32'(PWRITE), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Zero-wait write; PRDATA nonzero to prove writes return 0.
    xfer(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 32'hCAFE_0000, 1'b0, 32'h0, 1'b0, 3);
    // Read with 3 wait states.
    xfer(1'b0, 32'h0000_2000, 32'h0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 6);
    // Slave error.
    xfer(1'b0, 32'h0000_3010, 32'h0, 0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 3);
    // Timeout; PSLAVEERR high throughout but PREADY never rises.
    xfer(1'b0, 32'h0001_0000, 32'h0, 1000, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 18);
    // PREADY on the 16th ACCESS cycle is a success.
    xfer(1'b0, 32'h0001_0000, 32'h0, 15, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0, 18);
    // Write with slave error after 14 waits.
    xfer(1'b1, 32'h0000_0004, 32'h0000_0001, 14, 32'h0000_00FF, 1'b1, 32'h0, 1'b1, 17);

    // Backpressure with cmd_valid held high across two commands.
    sl_ws = 0; sl_rdata = 32'hA5A5_0001; sl_err = 1'b0;
    rsp_ready = 1'b0;
    push(1'b0, 32'h0000_6000, 32'h0, 32'hA5A5_0001, 1'b0, 3);
    push(1'b1, 32'h0000_6004, 32'h55AA_55AA, 32'h0, 1'b0, 3);
    @(posedge PCLK);
    #1;
    cmd_write = 1'b0; cmd_addr = 32'h0000_6000; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    wait_accept();
    @(posedge PCLK);
    #1;
    cmd_write = 1'b1; cmd_addr = 32'h0000_6004; cmd_wdata = 32'h55AA_55AA;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (rsp_valid) break;
    end
    chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
    repeat (4) @(negedge PCLK);
    @(posedge PCLK);
    #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK);
      if (in_xfer) break;
    end
    chk("b2b_accept_gap", acc_cyc - last_hs, 32'd1);
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    wait_rsp();

    // Reset during ACCESS abandons the transfer without a response.
    sl_ws = 1000;
    issue(1'b0, 32'h0000_7000, 32'h0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("mid_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b0;
    #1;
    chk("arst_psel", 32'(PSEL), 32'd0);
    chk("arst_penable", 32'(PENABLE), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (25) @(negedge PCLK);
    chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
    chk("no_stale_psel", 32'(PSEL), 32'd0);

    xfer(1'b1, 32'h0000_5000, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 32'h0, 1'b0, 3);

    repeat (2) @(posedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
